wbits_interleave: RTL and testbench
===================================

WBITS_INTERLEAVE -- requirements
Module: wbits_interleave

Interface
REQ-001 Parameter: NUM_SIGS, 4, number of signals interleaved per instruction; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Parameter: STRIDE, 9, byte distance between consecutive signal records in memory.
REQ-003 Derived constant: BPS = 32/NUM_SIGS, bits taken per signal.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle instruction start.
REQ-007 mode_i  input  1  0 = overwrite, 1 = merge result with rd_i; sampled with start_i.
REQ-008 address_i  input  32  base address of signal 0 (rs0); sampled with start_i.
REQ-009 rd_i  input  32  current destination value, used in merge mode; sampled with start_i.
REQ-010 read_if  modport  if_rmem.read_coproc  memory read port: start (out, 1), addr (out, 32), rdata (in, 32), done (in, 1).
REQ-011 rd_o  output  32  result word; valid only while done_o=1.
REQ-012 inc_addr_o  output  32  address increment for the caller; valid only while done_o=1.
REQ-013 done_o  output  1  single-cycle completion strobe.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, READ and DONE.
REQ-016 IDLE: on start_i, the block SHALL latch address_i, rd_i and mode_i, clear the accumulator and signal counter, drive read_if.start=1 in the same cycle, and go to READ.
REQ-017 read_if.addr SHALL equal latched_base + sig*STRIDE (32-bit wrap-around), where sig is the current signal counter; in the start cycle sig=0 and the base is taken directly from address_i.
REQ-018 READ: on read_if.done, the block SHALL OR spread(rdata) into the accumulator at the next clock edge, then:
- if sig < NUM_SIGS-1: increment sig and drive read_if.start=1 in that same cycle, with the next address;
- otherwise: go to DONE.
REQ-019 Spreading SHALL map rdata bit i of signal s to accumulator bit i*NUM_SIGS+s, for i = 0..BPS-1; rdata bits BPS..31 SHALL be ignored.
REQ-020 DONE: for exactly one cycle the block SHALL drive:
- done_o=1;
- rd_o = acc when mode=0, or acc | latched rd_i when mode=1;
- inc_addr_o = NUM_SIGS*STRIDE.
It SHALL then return to IDLE.
REQ-021 Outside DONE, rd_o, inc_addr_o and done_o SHALL be 0.
REQ-022 read_if.start SHALL be 0 except in the cycles named in REQ-016 and REQ-018.
REQ-023 Latency: with memory done arriving L>=1 cycles after each read_if.start, done_o SHALL assert L*NUM_SIGS+1 cycles after start_i.
REQ-024 start_i SHALL be ignored while busy_o=1, including in the DONE cycle.
REQ-025 read_if.done SHALL be ignored outside READ.
REQ-026 NUM_SIGS=1 SHALL perform one read and copy rdata to rd_o unchanged.

Reset
REQ-027 Asserting rst_ni SHALL immediately force state=IDLE, accumulator=0, sig=0, all latched values=0, all outputs=0 and read_if.start=0.
REQ-028 Reset mid-operation SHALL abort the operation without asserting done_o; the next start_i SHALL produce a result with no residue from the aborted run.

Structure
REQ-029 The state typedef wbits_il_state_t and the constant WBITS_MAX_SIGS=32 SHALL be placed in custom_instr_pkg.
REQ-030 The spreading function SHALL be a combinational sub-module, wbits_spread, parameterised by NUM_SIGS, with inputs rdata and sig and a 32-bit output.
REQ-031 The accumulator and signal counter SHALL be the only datapath registers; sig SHALL be $clog2(NUM_SIGS)+1 bits wide.

Verification
REQ-032 NUM_SIGS=4, mode=0, base 0x100, all reads return 0xFF, L=1 -> read addresses 0x100, 0x109, 0x112, 0x11B; rd_o=0xFFFFFFFF; inc_addr_o=36; done_o in cycle 5.
REQ-033 NUM_SIGS=4, signal 0 returns 0x01 and the rest 0 -> rd_o=0x00000001; separately, signal 3 returns 0x80 and the rest 0 -> rd_o=0x80000000.
REQ-034 NUM_SIGS=8, signal 0 returns 0xFFFFFF0F and the rest 0 -> rd_o=0x01010101; upper rdata bits are ignored.
REQ-035 mode=1, rd_i=0x0000FF00, all reads 0 -> rd_o=0x0000FF00; then mode=0 with the same data -> rd_o=0.
REQ-036 Reset asserted while waiting for signal 2, then a new start with all reads returning 0 -> no done_o from the aborted run; new rd_o=0.
REQ-037 start_i pulsed during READ and DONE, and read_if.done pulsed in IDLE -> no extra reads, no state change, exactly one done_o per accepted start.

Source files
------------

// File: rtl/custom_instr_pkg.sv
// rtl/custom_instr_pkg.sv - shared types and constants for the custom instruction blocks
//
// Contents:
//   WBITS_MAX_SIGS    width of the result word and the largest legal signal count
//   wbits_il_state_t  state encoding of the wbits_interleave sequencer
//   wbits_sig_width   width of a signal counter able to hold 0..num_sigs
package custom_instr_pkg;

  localparam int WBITS_MAX_SIGS = 32;

  typedef enum logic [1:0] {
    WBITS_IL_IDLE = 2'd0,
    WBITS_IL_READ = 2'd1,
    WBITS_IL_DONE = 2'd2
  } wbits_il_state_t;

  function automatic int wbits_sig_width(input int num_sigs);
    return $clog2(num_sigs) + 1;
  endfunction

endpackage

// File: rtl/if_rmem.sv
// rtl/if_rmem.sv - single-outstanding memory read port between a coprocessor and memory
//
// Signals:
//   start  1   read request strobe, one cycle per read
//   addr   32  byte address of the read, valid with start
//   rdata  32  read data, valid with done
//   done   1   read completion strobe
// Modports:
//   read_coproc  requester side (drives start/addr)
//   mem          responder side (drives rdata/done)
interface if_rmem;

  logic        start;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        done;

  modport read_coproc (
    output start,
    output addr,
    input  rdata,
    input  done
  );

  modport mem (
    input  start,
    input  addr,
    output rdata,
    output done
  );

endinterface

// File: rtl/wbits_spread.sv
// rtl/wbits_spread.sv - combinational bit spreader for one interleaved signal
//
// Ports:
//   rdata   in   32                  raw signal record; only the low BPS bits are used
//   sig     in   $clog2(NUM_SIGS)+1  index of the signal this record belongs to
//   spread  out  32                  rdata bit i placed at bit i*NUM_SIGS+sig, zeros elsewhere
module wbits_spread
  import custom_instr_pkg::*;
#(
  parameter int NUM_SIGS = 4
) (
  input  logic [31:0]               rdata,
  input  logic [$clog2(NUM_SIGS):0] sig,
  output logic [31:0]               spread
);

  localparam int BPS = WBITS_MAX_SIGS / NUM_SIGS;

  // Signal s occupies every NUM_SIGS-th bit starting at s. The index is
  // formed in 5 bits; for legal sig values it never exceeds 31.
  always_comb begin
    spread = '0;
    for (int i = 0; i < BPS; i++) begin
      spread[5'(i * NUM_SIGS) + 5'(sig)] = rdata[i];
    end
  end

endmodule

// File: rtl/wbits_interleave.sv
// rtl/wbits_interleave.sv - gathers NUM_SIGS signal records and bit-interleaves them into one word
//
// Ports:
//   clk_i       in   1   clock
//   rst_ni      in   1   asynchronous active-low reset
//   start_i     in   1   instruction start strobe, ignored while busy
//   mode_i      in   1   0 = overwrite, 1 = OR result into rd_i (sampled with start_i)
//   address_i   in   32  address of signal 0 record (sampled with start_i)
//   rd_i        in   32  current destination value (sampled with start_i)
//   read_if     port     memory read requester, one read outstanding at a time
//   rd_o        out  32  result word, nonzero only while done_o
//   inc_addr_o  out  32  NUM_SIGS*STRIDE, nonzero only while done_o
//   done_o      out  1   one-cycle completion strobe
//   busy_o      out  1   high whenever the sequencer is not idle
module wbits_interleave
  import custom_instr_pkg::*;
#(
  parameter int NUM_SIGS = 4,
  parameter int STRIDE   = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [31:0] address_i,
  input  logic [31:0] rd_i,
  if_rmem.read_coproc read_if,
  output logic [31:0] rd_o,
  output logic [31:0] inc_addr_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam int                SIG_W    = wbits_sig_width(NUM_SIGS);
  localparam logic [SIG_W-1:0]  LAST_SIG = SIG_W'(NUM_SIGS - 1);
  localparam logic [31:0]       STRIDE_W = 32'(STRIDE);
  localparam logic [31:0]       INC_W    = 32'(NUM_SIGS * STRIDE);

  wbits_il_state_t  state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] sig_inc;
  logic [31:0]      base_q;
  logic [31:0]      rd_q;
  logic             mode_q;
  logic             latch_en;
  logic [31:0]      spread;
  logic             mem_start;
  logic [31:0]      mem_addr;

  // Byte offset of a signal record from the base, wrapping at 32 bits.
  function automatic logic [31:0] sig_offset(input logic [SIG_W-1:0] s);
    return 32'(s) * STRIDE_W;
  endfunction

  assign sig_inc = sig_q + SIG_W'(1);

  wbits_spread #(
    .NUM_SIGS (NUM_SIGS)
  ) u_spread (
    .rdata  (read_if.rdata),
    .sig    (sig_q),
    .spread (spread)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sig_d      = sig_q;
    latch_en   = 1'b0;
    mem_start  = 1'b0;
    mem_addr   = base_q + sig_offset(sig_q);
    rd_o       = '0;
    inc_addr_o = '0;
    done_o     = 1'b0;

    case (state_q)
      WBITS_IL_IDLE: begin
        if (start_i) begin
          latch_en  = 1'b1;
          acc_d     = '0;
          sig_d     = '0;
          // The base is not latched yet, so the first read uses address_i directly.
          mem_start = 1'b1;
          mem_addr  = address_i;
          state_d   = WBITS_IL_READ;
        end
      end

      WBITS_IL_READ: begin
        if (read_if.done) begin
          acc_d = acc_q | spread;
          // sig never exceeds LAST_SIG, so inequality means more signals remain.
          if (sig_q != LAST_SIG) begin
            sig_d     = sig_inc;
            mem_start = 1'b1;
            mem_addr  = base_q + sig_offset(sig_inc);
          end else begin
            state_d = WBITS_IL_DONE;
          end
        end
      end

      WBITS_IL_DONE: begin
        done_o     = 1'b1;
        rd_o       = mode_q ? (acc_q | rd_q) : acc_q;
        inc_addr_o = INC_W;
        state_d    = WBITS_IL_IDLE;
      end

      default: begin
        state_d = WBITS_IL_IDLE;
      end
    endcase
  end

  // The IDLE start path is combinational from start_i, so it is gated by
  // reset to keep the memory port quiet while reset is held.
  assign read_if.start = mem_start & rst_ni;
  assign read_if.addr  = rst_ni ? mem_addr : '0;
  assign busy_o        = (state_q != WBITS_IL_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WBITS_IL_IDLE;
      acc_q   <= '0;
      sig_q   <= '0;
      base_q  <= '0;
      rd_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sig_q   <= sig_d;
      if (latch_en) begin
        base_q <= address_i;
        rd_q   <= rd_i;
        mode_q <= mode_i;
      end
    end
  end

endmodule

// File: tb/tb_wbits_interleave.sv
// tb/tb_wbits_interleave.sv - directed self-checking bench for wbits_interleave (NUM_SIGS 4, 8, 1)
module tb_wbits_interleave;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        mode      = 1'b0;
  logic        spur_done = 1'b0;
  logic [31:0] addr      = '0;
  logic [31:0] rd        = '0;
  logic [31:0] base_v    = '0;
  logic [31:0] sig_data [32];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Memory image: signal record s lives at base_v + 9*s.
  function automatic logic [31:0] lookup(input logic [31:0] a);
    logic [31:0] off;
    off = (a - base_v) / 32'd9;
    if (off < 32'd32) return sig_data[off[4:0]];
    return '0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NS = (g == 0) ? 4 : ((g == 1) ? 8 : 1);

    if_rmem rif ();

    logic [31:0] rd_o;
    logic [31:0] inc;
    logic        done;
    logic        busy;
    logic        mem_done_q  = 1'b0;
    logic [31:0] mem_rdata_q = '0;

    int          cyc         = 0;
    int          nreads      = 0;
    int          ndone       = 0;
    int          start_cyc   = 0;
    int          done_cyc    = 0;
    int          outside_bad = 0;
    logic [31:0] last_rd     = '0;
    logic [31:0] last_inc    = '0;
    logic [31:0] raddr [16];

    wbits_interleave #(
      .NUM_SIGS (NS),
      .STRIDE   (9)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .mode_i     (mode),
      .address_i  (addr),
      .rd_i       (rd),
      .read_if    (rif),
      .rd_o       (rd_o),
      .inc_addr_o (inc),
      .done_o     (done),
      .busy_o     (busy)
    );

    assign rif.done  = mem_done_q | spur_done;
    assign rif.rdata = mem_rdata_q;

    // One-cycle memory latency.
    always @(posedge clk) begin
      mem_done_q  <= rif.start;
      mem_rdata_q <= lookup(rif.addr);
    end

    always @(negedge clk) begin
      cyc = cyc + 1;
      if (start && !busy) start_cyc = cyc;
      if (rif.start) begin
        raddr[nreads % 16] = rif.addr;
        nreads = nreads + 1;
      end
      if (done) begin
        ndone    = ndone + 1;
        done_cyc = cyc;
        last_rd  = rd_o;
        last_inc = inc;
      end else if (rd_o != '0 || inc != '0) begin
        outside_bad = outside_bad + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] fill, input int s, input logic [31:0] v);
    for (int i = 0; i < 32; i++) sig_data[i] = fill;
    sig_data[s] = v;
  endtask

  task automatic pulse_start(input logic m, input logic [31:0] a, input logic [31:0] r);
    @(posedge clk);
    #1;
    mode   = m;
    addr   = a;
    rd     = r;
    base_v = a;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_all(input int t0, input int t1, input int t2);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk);
      #2;
      ok = (g_dut[0].ndone >= t0) && (g_dut[1].ndone >= t1) && (g_dut[2].ndone >= t2);
    end
    check_eq("wait_done", {31'b0, ok}, 32'd1);
  endtask

  task automatic check_inst(input string pfx,
                            input logic [31:0] got_rd, input logic [31:0] exp_rd,
                            input logic [31:0] got_inc, input logic [31:0] exp_inc,
                            input logic [31:0] got_lat, input logic [31:0] exp_lat,
                            input logic [31:0] got_nr, input logic [31:0] exp_nr,
                            input logic [31:0] got_nd);
    check_eq($sformatf("%s_rd", pfx), got_rd, exp_rd);
    check_eq($sformatf("%s_inc", pfx), got_inc, exp_inc);
    check_eq($sformatf("%s_latency", pfx), got_lat, exp_lat);
    check_eq($sformatf("%s_reads", pfx), got_nr, exp_nr);
    check_eq($sformatf("%s_dones", pfx), got_nd, 32'd1);
  endtask

  typedef struct {
    logic        m;
    logic [31:0] base;
    logic [31:0] rdv;
    logic [31:0] fill;
    int          s;
    logic [31:0] v;
    logic [31:0] e4;
    logic [31:0] e8;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int b0, b1, b2, d0, d1, d2;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         32'hFF, 0, 32'hFF,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[1] = '{1'b0, 32'h0000_0200, 32'h0,         32'h00, 0, 32'h01,        32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         32'h00, 3, 32'h80,        32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0300, 32'h0,         32'h00, 0, 32'hFFFF_FF0F, 32'h0000_1111, 32'h0101_0101, 32'hFFFF_FF0F};
    vecs[4] = '{1'b1, 32'h0000_0400, 32'h0000_FF00, 32'h00, 0, 32'h00,        32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00};
    vecs[5] = '{1'b0, 32'h0000_0400, 32'h0000_FF00, 32'h00, 0, 32'h00,        32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         32'h03, 0, 32'h03,        32'h0000_00FF, 32'h0000_FFFF, 32'h0000_0003};

    set_data(32'h0, 0, 32'h0);

    // Reset state, including start_i held high while in reset.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    addr  = 32'h1234_5678;
    #1;
    check_eq("rst_mem_start", {31'b0, g_dut[0].rif.start}, 32'd0);
    check_eq("rst_mem_addr", g_dut[0].rif.addr, 32'h0);
    check_eq("rst_busy", {31'b0, g_dut[0].busy}, 32'd0);
    check_eq("rst_done", {31'b0, g_dut[0].done}, 32'd0);
    check_eq("rst_rd_o", g_dut[0].rd_o, 32'h0);
    check_eq("rst_inc", g_dut[0].inc, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_busy_after_edge", {31'b0, g_dut[0].busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    // Directed vectors through all three instances at once.
    for (int v = 0; v < 7; v++) begin
      set_data(vecs[v].fill, vecs[v].s, vecs[v].v);
      b0 = g_dut[0].nreads; b1 = g_dut[1].nreads; b2 = g_dut[2].nreads;
      d0 = g_dut[0].ndone;  d1 = g_dut[1].ndone;  d2 = g_dut[2].ndone;
      pulse_start(vecs[v].m, vecs[v].base, vecs[v].rdv);
      wait_all(d0 + 1, d1 + 1, d2 + 1);
      check_inst($sformatf("v%0d_n4", v), g_dut[0].last_rd, vecs[v].e4, g_dut[0].last_inc, 32'd36,
                 32'(g_dut[0].done_cyc - g_dut[0].start_cyc), 32'd5,
                 32'(g_dut[0].nreads - b0), 32'd4, 32'(g_dut[0].ndone - d0));
      check_inst($sformatf("v%0d_n8", v), g_dut[1].last_rd, vecs[v].e8, g_dut[1].last_inc, 32'd72,
                 32'(g_dut[1].done_cyc - g_dut[1].start_cyc), 32'd9,
                 32'(g_dut[1].nreads - b1), 32'd8, 32'(g_dut[1].ndone - d1));
      check_inst($sformatf("v%0d_n1", v), g_dut[2].last_rd, vecs[v].e1, g_dut[2].last_inc, 32'd9,
                 32'(g_dut[2].done_cyc - g_dut[2].start_cyc), 32'd2,
                 32'(g_dut[2].nreads - b2), 32'd1, 32'(g_dut[2].ndone - d2));
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("v%0d_n4_addr%0d", v, j), g_dut[0].raddr[(b0 + j) % 16],
                 vecs[v].base + 32'(j * 9));
      end
    end

    // Reset while signal 2 is outstanding, then a clean run with zero data.
    set_data(32'hFF, 0, 32'hFF);
    d0 = g_dut[0].ndone; d1 = g_dut[1].ndone;
    pulse_start(1'b0, 32'h0000_0600, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy_n4", {31'b0, g_dut[0].busy}, 32'd0);
    check_eq("abort_busy_n8", {31'b0, g_dut[1].busy}, 32'd0);
    check_eq("abort_mem_start", {31'b0, g_dut[0].rif.start}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_eq("abort_no_done_n4", 32'(g_dut[0].ndone - d0), 32'd0);
    check_eq("abort_no_done_n8", 32'(g_dut[1].ndone - d1), 32'd0);
    set_data(32'h0, 0, 32'h0);
    d0 = g_dut[0].ndone; d1 = g_dut[1].ndone; d2 = g_dut[2].ndone;
    pulse_start(1'b0, 32'h0000_0600, 32'h0);
    wait_all(d0 + 1, d1 + 1, d2 + 1);
    check_eq("post_abort_rd_n4", g_dut[0].last_rd, 32'h0);
    check_eq("post_abort_rd_n8", g_dut[1].last_rd, 32'h0);
    check_eq("post_abort_rd_n1", g_dut[2].last_rd, 32'h0);
    check_eq("post_abort_dones_n4", 32'(g_dut[0].ndone - d0), 32'd1);

    // start_i pulsed during READ (cycle 2) and during the N4 DONE cycle (cycle 5).
    set_data(32'h0, 0, 32'h01);
    b0 = g_dut[0].nreads; b1 = g_dut[1].nreads;
    d0 = g_dut[0].ndone;  d1 = g_dut[1].ndone;
    @(posedge clk); #1; mode = 1'b0; addr = 32'h0000_0700; base_v = addr; rd = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_all(d0 + 1, d1 + 1, 0);
    repeat (5) @(posedge clk);
    #2;
    check_eq("busy_start_reads_n4", 32'(g_dut[0].nreads - b0), 32'd4);
    check_eq("busy_start_dones_n4", 32'(g_dut[0].ndone - d0), 32'd1);
    check_eq("busy_start_reads_n8", 32'(g_dut[1].nreads - b1), 32'd8);
    check_eq("busy_start_dones_n8", 32'(g_dut[1].ndone - d1), 32'd1);
    check_eq("busy_start_rd_n4", g_dut[0].last_rd, 32'h0000_0001);

    // Spurious memory done while idle.
    b0 = g_dut[0].nreads; d0 = g_dut[0].ndone;
    @(posedge clk); #1; spur_done = 1'b1;
    @(posedge clk); #1; spur_done = 1'b0;
    @(posedge clk);
    #2;
    check_eq("spur_busy_n4", {31'b0, g_dut[0].busy}, 32'd0);
    check_eq("spur_reads_n4", 32'(g_dut[0].nreads - b0), 32'd0);
    check_eq("spur_dones_n4", 32'(g_dut[0].ndone - d0), 32'd0);

    check_eq("outside_done_n4", 32'(g_dut[0].outside_bad), 32'd0);
    check_eq("outside_done_n8", 32'(g_dut[1].outside_bad), 32'd0);
    check_eq("outside_done_n1", 32'(g_dut[2].outside_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
